// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART bus bridge: register map, bit positions
// and the TX state encoding.
package uart_bus_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_RXCOUNT = 2'd3;

  localparam int STAT_RXAVAIL = 0;
  localparam int STAT_TXRDY   = 1;
  localparam int STAT_RXOVR   = 2;
  localparam int STAT_TXIDLE  = 3;
  localparam int STAT_TXDROP  = 4;
  localparam int STAT_IRQ     = 7;

  localparam int CTRL_RXIE  = 0;
  localparam int CTRL_TXIE  = 1;
  localparam int CTRL_FLUSH = 7;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_ACK  = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// 6502-side register bus plus UART-core handshake, as seen by the bridge.
// UART TX handshake: the bridge raises uart_tx_start for one clk with
// uart_tx_data valid; the core answers with uart_tx_busy high for the whole
// byte, and the bridge never starts another byte while busy is high.
interface uart_bus_bridge_if;
  logic       cpu_en;
  logic       cpu_cs;
  logic       cpu_we;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_irq;
  logic [7:0] uart_rx_data;
  logic       uart_rx_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_start;
  logic       uart_tx_busy;

  modport slave (
    input  cpu_en, cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    input  uart_rx_data, uart_rx_ready, uart_tx_busy,
    output cpu_rdata, cpu_irq, uart_tx_data, uart_tx_start
  );

  modport master (
    output cpu_en, cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    output uart_rx_data, uart_rx_ready, uart_tx_busy,
    input  cpu_rdata, cpu_irq, uart_tx_data, uart_tx_start
  );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push and pop in the same clk both succeed even
// when full. Flush overrides any same-clk push or pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_bus_bridge.sv
// CPU register front end for the UART core: RX/TX FIFOs, status/control
// registers, level IRQ and the tx_start/tx_busy sequencer.
module uart_bus_bridge
  import uart_bus_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  uart_bus_bridge_if.slave         bus,
  output tx_state_t                tx_state_dbg,
  output logic [$clog2(TX_DEPTH):0] tx_level_dbg
);
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic             acc, rd, wr;
  logic             rd_data, status_rd, data_wr, flush;
  logic             rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_head;
  logic [RX_CW-1:0] rx_count;
  logic [8:0]       rx_count_w;
  logic [7:0]       rx_count_sat;
  logic             tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic             launch, tx_idle;
  logic             rxie, txie, rxovr, txdrop;
  logic [7:0]       status, rd_mux;
  tx_state_t        tx_state;

  assign acc       = bus.cpu_en & bus.cpu_cs;
  assign rd        = acc & ~bus.cpu_we;
  assign wr        = acc & bus.cpu_we;
  assign rd_data   = rd & (bus.cpu_addr == REG_DATA);
  assign status_rd = rd & (bus.cpu_addr == REG_STATUS);
  assign data_wr   = wr & (bus.cpu_addr == REG_DATA);
  assign flush     = wr & (bus.cpu_addr == REG_CTRL) & bus.cpu_wdata[CTRL_FLUSH];

  assign rx_pop = rd_data & ~rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.uart_rx_ready),
    .pop     (rx_pop),
    .flush   (flush),
    .din     (bus.uart_rx_data),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_wr),
    .pop     (tx_pop),
    .flush   (flush),
    .din     (bus.cpu_wdata),
    .dout    (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_level_dbg)
  );

  // A new byte may launch from idle, or straight out of WAIT_DONE so that
  // back-to-back bytes start one clk after busy falls.
  assign launch  = ~tx_empty & ~bus.uart_tx_busy & ~flush &
                   ((tx_state == TX_IDLE) | (tx_state == TX_WAIT_DONE));
  assign tx_pop  = launch;
  assign tx_idle = tx_empty & (tx_state == TX_IDLE) & ~bus.uart_tx_busy;

  assign rx_count_w   = 9'(rx_count);
  assign rx_count_sat = rx_count_w[8] ? 8'hFF : rx_count_w[7:0];

  always_comb begin
    status               = 8'h00;
    status[STAT_RXAVAIL] = ~rx_empty;
    status[STAT_TXRDY]   = ~tx_full;
    status[STAT_RXOVR]   = rxovr;
    status[STAT_TXIDLE]  = tx_idle;
    status[STAT_TXDROP]  = txdrop;
    status[STAT_IRQ]     = bus.cpu_irq;
    case (bus.cpu_addr)
      REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux = {6'b0, txie, rxie};
      default:    rd_mux = rx_count_sat;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cpu_rdata <= 8'h00;
      bus.cpu_irq   <= 1'b0;
      rxie          <= 1'b0;
      txie          <= 1'b0;
      rxovr         <= 1'b0;
      txdrop        <= 1'b0;
    end else begin
      if (rd) bus.cpu_rdata <= rd_mux;
      if (wr && bus.cpu_addr == REG_CTRL) begin
        rxie <= bus.cpu_wdata[CTRL_RXIE];
        txie <= bus.cpu_wdata[CTRL_TXIE];
      end
      // Sticky flags: flush clears, a set event beats a STATUS-read clear.
      if (flush)                                       rxovr <= 1'b0;
      else if (bus.uart_rx_ready && rx_full && !rx_pop) rxovr <= 1'b1;
      else if (status_rd)                              rxovr <= 1'b0;
      if (flush)                                       txdrop <= 1'b0;
      else if (data_wr && tx_full && !tx_pop)          txdrop <= 1'b1;
      else if (status_rd)                              txdrop <= 1'b0;
      bus.cpu_irq <= (rxie & ~rx_empty) |
                     (txie & tx_empty & (tx_state == TX_IDLE));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state          <= TX_IDLE;
      bus.uart_tx_start <= 1'b0;
      bus.uart_tx_data  <= 8'h00;
    end else begin
      bus.uart_tx_start <= launch;
      if (launch) bus.uart_tx_data <= tx_head;
      case (tx_state)
        TX_IDLE:      if (launch) tx_state <= TX_START;
        TX_START:     tx_state <= TX_WAIT_ACK;
        TX_WAIT_ACK:  if (bus.uart_tx_busy) tx_state <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!bus.uart_tx_busy) tx_state <= launch ? TX_START : TX_IDLE;
        default:      tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_state_dbg = tx_state;
endmodule
